// File: rtl/fetch_npc_unit_pkg.sv
// rtl/fetch_npc_unit_pkg.sv - next-PC select codes, NOP encoding and fetch FSM states
package fetch_npc_unit_pkg;

    localparam logic [3:0] NPC_PC4 = 4'd0;
    localparam logic [3:0] NPC_B   = 4'd1;
    localparam logic [3:0] NPC_JMP = 4'd2;
    localparam logic [3:0] NPC_ALU = 4'd3;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef enum logic [1:0] {
        FS_IDLE  = 2'd0,
        FS_FETCH = 2'd1,
        FS_VALID = 2'd2,
        FS_ERR   = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/fetch_npc_unit_npc_calc.sv
// rtl/fetch_npc_unit_npc_calc.sv - combinational next-PC mux (PC+4 / branch / JAL / JALR)
module npc_calc
    import fetch_npc_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] pc_i,
    input  logic [3:0]      npc_op_i,
    input  logic            br_taken_i,
    input  logic [XLEN-1:0] imm_i,
    input  logic [XLEN-1:0] alu_c_i,
    output logic [XLEN-1:0] npc_o
);

    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] pc_plus_imm;

    assign pc_plus4    = pc_i + XLEN'(4);
    assign pc_plus_imm = pc_i + imm_i;

    always_comb begin
        npc_o = pc_plus4;
        case (npc_op_i)
            NPC_PC4: npc_o = pc_plus4;
            NPC_B:   npc_o = br_taken_i ? pc_plus_imm : pc_plus4;
            NPC_JMP: npc_o = pc_plus_imm;
            // JALR clears bit 0 of the computed target
            NPC_ALU: npc_o = alu_c_i & ~XLEN'(1);
            default: npc_o = pc_plus4;
        endcase
    end

endmodule

// File: rtl/fetch_npc_unit.sv
// rtl/fetch_npc_unit.sv - fetch stage: PC register, IROM req/ack FSM, next-PC on commit
// Optional misaligned-target trap enabled by FETCH_MISALIGN_CHECK_EN.
module fetch_npc_unit
    import fetch_npc_unit_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            cpu_clk,
    input  logic            cpu_rst,
    output logic            irom_req,
    output logic [XLEN-1:0] irom_addr,
    input  logic            irom_ack,
    input  logic [31:0]     irom_rdata,
    output logic [31:0]     inst,
    output logic            inst_valid,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc4,
    input  logic            commit,
    input  logic [3:0]      npc_op,
    input  logic            br_taken,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] alu_c,
    output logic            fetch_err
);

    fetch_state_e    state_q;
    logic [XLEN-1:0] pc_q;
    logic [31:0]     inst_q;
    logic            inst_valid_q;
    logic            irom_req_q;
    logic [XLEN-1:0] npc_d;

    npc_calc #(.XLEN(XLEN)) u_npc_calc (
        .pc_i       (pc_q),
        .npc_op_i   (npc_op),
        .br_taken_i (br_taken),
        .imm_i      (imm),
        .alu_c_i    (alu_c),
        .npc_o      (npc_d)
    );

`ifdef FETCH_MISALIGN_CHECK_EN
    logic fetch_err_q;
    assign fetch_err = fetch_err_q;
`else
    assign fetch_err = 1'b0;
`endif

    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            state_q      <= FS_IDLE;
            pc_q         <= RESET_PC;
            inst_q       <= NOP_INST;
            inst_valid_q <= 1'b0;
            irom_req_q   <= 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
            fetch_err_q  <= 1'b0;
`endif
        end else begin
            case (state_q)
                FS_IDLE: begin
                    irom_req_q <= 1'b1;
                    state_q    <= FS_FETCH;
                end
                FS_FETCH: begin
                    if (irom_ack) begin
                        inst_q       <= irom_rdata;
                        inst_valid_q <= 1'b1;
                        irom_req_q   <= 1'b0;
                        state_q      <= FS_VALID;
                    end
                end
                FS_VALID: begin
                    if (commit) begin
                        inst_valid_q <= 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
                        pc_q <= npc_d;
                        if (npc_d[1:0] != 2'b00) begin
                            fetch_err_q <= 1'b1;
                            state_q     <= FS_ERR;
                        end else begin
                            irom_req_q <= 1'b1;
                            state_q    <= FS_FETCH;
                        end
`else
                        pc_q       <= npc_d & ~XLEN'(3);
                        irom_req_q <= 1'b1;
                        state_q    <= FS_FETCH;
`endif
                    end
                end
                default: begin
                    // trapped: only cpu_rst leaves this state
                    irom_req_q   <= 1'b0;
                    inst_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign irom_req   = irom_req_q;
    assign irom_addr  = pc_q;
    assign inst       = inst_q;
    assign inst_valid = inst_valid_q;
    assign pc         = pc_q;
    assign pc4        = pc_q + XLEN'(4);

endmodule

// File: tb/tb_fetch_npc_unit.sv
// tb/tb_fetch_npc_unit.sv - self-checking bench for fetch_npc_unit
module tb_fetch_npc_unit;
    import fetch_npc_unit_pkg::*;

    logic        cpu_clk = 1'b0;
    logic        cpu_rst;
    logic        irom_req;
    logic [31:0] irom_addr;
    logic        irom_ack;
    logic [31:0] irom_rdata;
    logic [31:0] inst;
    logic        inst_valid;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        commit;
    logic [3:0]  npc_op;
    logic        br_taken;
    logic [31:0] imm;
    logic [31:0] alu_c;
    logic        fetch_err;

    fetch_npc_unit #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
        .cpu_clk    (cpu_clk),
        .cpu_rst    (cpu_rst),
        .irom_req   (irom_req),
        .irom_addr  (irom_addr),
        .irom_ack   (irom_ack),
        .irom_rdata (irom_rdata),
        .inst       (inst),
        .inst_valid (inst_valid),
        .pc         (pc),
        .pc4        (pc4),
        .commit     (commit),
        .npc_op     (npc_op),
        .br_taken   (br_taken),
        .imm        (imm),
        .alu_c      (alu_c),
        .fetch_err  (fetch_err)
    );

    always #5 cpu_clk = ~cpu_clk;

    typedef struct {
        logic [31:0] start_pc;
        logic [3:0]  op;
        logic        br;
        logic [31:0] imm;
        logic [31:0] alu;
        logic [31:0] exp_addr;
    } vec_t;

    vec_t        vecs[9];
    logic [31:0] exp_q[$];
    int          nvec  = 0;
    int          nfail = 0;

    task automatic step();
        @(posedge cpu_clk);
        #1;
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_req_and_score(input string name);
        int n;
        logic [31:0] e;
        n = 0;
        while (irom_req !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        if (irom_req !== 1'b1) begin
            nvec++;
            nfail++;
            $display("FAIL %s: no irom_req within 20 cycles, expected one", name);
        end else if (exp_q.size() == 0) begin
            nvec++;
            nfail++;
            $display("FAIL %s: irom_req with addr %h but scoreboard empty", name, irom_addr);
        end else begin
            e = exp_q.pop_front();
            check32(name, irom_addr, e);
        end
    endtask

    task automatic do_fetch(input string name, input logic [31:0] data, input int delay);
        repeat (delay) step();
        irom_ack   = 1'b1;
        irom_rdata = data;
        step();
        irom_ack   = 1'b0;
        check32({name, " inst_valid"}, {31'b0, inst_valid}, 32'd1);
        check32({name, " inst"}, inst, data);
    endtask

    task automatic do_commit(input logic [3:0] op, input logic br, input logic [31:0] im,
                             input logic [31:0] alu, input logic [31:0] exp_addr);
        npc_op   = op;
        br_taken = br;
        imm      = im;
        alu_c    = alu;
        commit   = 1'b1;
        exp_q.push_back(exp_addr);
        step();
        commit   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{32'h0000_0010, NPC_B,   1'b1, 32'hFFFF_FFF8, 32'h0, 32'h0000_0008};
        vecs[1] = '{32'h0000_0010, NPC_B,   1'b0, 32'hFFFF_FFF8, 32'h0, 32'h0000_0014};
        vecs[2] = '{32'h0000_0020, NPC_ALU, 1'b0, 32'h0, 32'h0000_1235, 32'h0000_1234};
        vecs[3] = '{32'h0000_0100, NPC_JMP, 1'b0, 32'h0000_07FC, 32'h0, 32'h0000_08FC};
        vecs[4] = '{32'hFFFF_FFFC, NPC_PC4, 1'b0, 32'h0, 32'h0, 32'h0000_0000};
        vecs[5] = '{32'h0000_0040, 4'd9,    1'b1, 32'h0000_0100, 32'h0, 32'h0000_0044};
        vecs[6] = '{32'h0000_0040, NPC_PC4, 1'b1, 32'h0000_0100, 32'h0, 32'h0000_0044};
        vecs[7] = '{32'h0000_0040, NPC_JMP, 1'b0, 32'hFFFF_FFC0, 32'h0, 32'h0000_0000};
        vecs[8] = '{32'h0000_0080, NPC_B,   1'b1, 32'h0000_0100, 32'h0, 32'h0000_0180};

        cpu_rst    = 1'b1;
        irom_ack   = 1'b0;
        irom_rdata = 32'h0;
        commit     = 1'b0;
        npc_op     = NPC_PC4;
        br_taken   = 1'b0;
        imm        = 32'h0;
        alu_c      = 32'h0;
        step();
        step();

        check32("rst irom_req", {31'b0, irom_req}, 32'd0);
        check32("rst inst_valid", {31'b0, inst_valid}, 32'd0);
        check32("rst inst", inst, 32'h0000_0013);
        check32("rst pc", pc, 32'h0);
        check32("rst pc4", pc4, 32'h4);
        check32("rst fetch_err", {31'b0, fetch_err}, 32'd0);

        cpu_rst = 1'b0;
        check32("bubble irom_req", {31'b0, irom_req}, 32'd0);
        step();
        check32("req after release", {31'b0, irom_req}, 32'd1);
        exp_q.push_back(32'h0);
        wait_req_and_score("first fetch addr");
        step();
        step();
        check32("req held", {31'b0, irom_req}, 32'd1);
        check32("addr held", irom_addr, 32'h0);
        check32("no valid before ack", {31'b0, inst_valid}, 32'd0);
        do_fetch("first", 32'h0050_0093, 1);
        check32("first pc4", pc4, 32'h4);
        check32("first req dropped", {31'b0, irom_req}, 32'd0);

        irom_ack   = 1'b1;
        irom_rdata = 32'hDEAD_BEEF;
        step();
        irom_ack   = 1'b0;
        step();
        check32("spurious ack inst", inst, 32'h0050_0093);
        check32("spurious ack valid", {31'b0, inst_valid}, 32'd1);
        check32("spurious ack req", {31'b0, irom_req}, 32'd0);

        for (int i = 0; i < 9; i++) begin
            do_commit(NPC_ALU, 1'b0, 32'h0, vecs[i].start_pc, vecs[i].start_pc);
            wait_req_and_score($sformatf("vec%0d setpc", i));
            do_fetch($sformatf("vec%0d setup", i), 32'h0000_0013 + (32'(i) << 7), 0);
            check32($sformatf("vec%0d pc4", i), pc4, vecs[i].start_pc + 32'd4);
            do_commit(vecs[i].op, vecs[i].br, vecs[i].imm, vecs[i].alu, vecs[i].exp_addr);
            wait_req_and_score($sformatf("vec%0d npc", i));
            check32($sformatf("vec%0d pc", i), pc, vecs[i].exp_addr);
            do_fetch($sformatf("vec%0d fetch", i), 32'h0010_0093 + 32'(i), 1);
        end

        do_commit(NPC_PC4, 1'b0, 32'h0, 32'h0, 32'h0000_0184);
        wait_req_and_score("pre-fetch-commit");
        npc_op = NPC_JMP;
        imm    = 32'h0000_0100;
        commit = 1'b1;
        step();
        commit = 1'b0;
        check32("commit in FETCH addr", irom_addr, 32'h0000_0184);
        check32("commit in FETCH pc", pc, 32'h0000_0184);
        check32("commit in FETCH req", {31'b0, irom_req}, 32'd1);
        check32("commit in FETCH valid", {31'b0, inst_valid}, 32'd0);
        do_fetch("after FETCH commit", 32'h0020_0113, 0);

`ifdef FETCH_MISALIGN_CHECK_EN
        npc_op = NPC_ALU;
        alu_c  = 32'h0000_1236;
        commit = 1'b1;
        step();
        commit = 1'b0;
        step();
        step();
        check32("misalign fetch_err", {31'b0, fetch_err}, 32'd1);
        check32("misalign req", {31'b0, irom_req}, 32'd0);
        check32("misalign valid", {31'b0, inst_valid}, 32'd0);
        check32("misalign pc", pc, 32'h0000_1236);
        cpu_rst = 1'b1;
        step();
        check32("err cleared by reset", {31'b0, fetch_err}, 32'd0);
        cpu_rst = 1'b0;
        exp_q.push_back(32'h0);
        wait_req_and_score("refetch after err");
        do_fetch("refetch after err", 32'h1111_1111, 0);
        do_commit(NPC_PC4, 1'b0, 32'h0, 32'h0, 32'h4);
        wait_req_and_score("fetch before abort");
`else
        do_commit(NPC_ALU, 1'b0, 32'h0, 32'h0000_1236, 32'h0000_1234);
        wait_req_and_score("misalign forced");
        check32("misalign no err", {31'b0, fetch_err}, 32'd0);
        do_fetch("misalign forced", 32'h1111_1111, 0);
        do_commit(NPC_PC4, 1'b0, 32'h0, 32'h0, 32'h0000_1238);
        wait_req_and_score("fetch before abort");
`endif

        step();
        #3;
        cpu_rst    = 1'b1;
        irom_ack   = 1'b1;
        irom_rdata = 32'h0BAD_0BAD;
        #1;
        check32("async rst req", {31'b0, irom_req}, 32'd0);
        check32("async rst pc", pc, 32'h0);
        check32("async rst inst", inst, 32'h0000_0013);
        check32("async rst valid", {31'b0, inst_valid}, 32'd0);
        step();
        cpu_rst = 1'b0;
        step();
        irom_ack = 1'b0;
        check32("late ack ignored inst", inst, 32'h0000_0013);
        check32("late ack ignored valid", {31'b0, inst_valid}, 32'd0);
        exp_q.push_back(32'h0);
        wait_req_and_score("restart addr");
        do_fetch("restart", 32'h00A0_0113, 1);
        check32("restart pc", pc, 32'h0);
        check32("scoreboard drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
